// File: rtl/udc_bus_master.sv
// Host-side strobe-bus initiator for the up/down counter peripheral.
// Commands arrive on a valid/ready channel; read data and status return on a valid/ready response channel.
module udc_bus_master #(
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_status,
    output logic              rsp_err,
    output logic              ncs,
    output logic              nrd,
    output logic              nwr,
    output logic              a0,
    output logic              a1,
    output logic [DATA_W-1:0] bus_dout,
    output logic              start,
    input  logic [DATA_W-1:0] bus_din,
    input  logic              err,
    input  logic              dir,
    input  logic              ec
);

    localparam int PHASE_CYC [3] = '{SETUP_CYC, STROBE_CYC, HOLD_CYC};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_param_chk
            if (PHASE_CYC[gi] < 1 || PHASE_CYC[gi] > 15) begin : g_bad
                $error("udc_bus_master: phase length %0d outside 1..15", PHASE_CYC[gi]);
            end
        end
    endgenerate

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic [1:0]          op_reg;
    logic [1:0]          addr_reg;
    logic [DATA_W-1:0]   data_reg;

    logic                ncs_reg, ncs_next;
    logic                nrd_reg, nrd_next;
    logic                nwr_reg, nwr_next;
    logic                start_reg, start_next;
    logic [1:0]          a_reg, a_next;
    logic [DATA_W-1:0]   dout_reg, dout_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic [2:0]          rsp_status_reg;
    logic                rsp_err_reg;

    logic                accept;
    logic                rsp_done;
    logic                capture;
    logic                bus_active;

    // Phase sequencing; one shared down-counter times every phase.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_ready_reg && cmd_valid) begin
                    accept = 1'b1;
                    case (cmd_op)
                        OP_WR, OP_RD: begin
                            state_next = SETUP;
                            cnt_next   = SETUP_LD;
                        end
                        OP_START: begin
                            state_next = STROBE;
                            cnt_next   = STROBE_LD;
                        end
                        default: state_next = RESP;
                    endcase
                end
            end
            SETUP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_reg == 4'd0) begin
                    if (op_reg == OP_START) begin
                        state_next = RESP;
                    end else begin
                        state_next = HOLD;
                        cnt_next   = HOLD_LD;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus pins are registered decodes of the current phase, so they trail the
    // state by one edge; this gives the idle cycle between acceptance and ncs.
    always_comb begin
        bus_active = (state_reg == SETUP) || (state_reg == HOLD) ||
                     ((state_reg == STROBE) && (op_reg != OP_START));
        ncs_next   = !bus_active;
        nwr_next   = !((state_reg == STROBE) && (op_reg == OP_WR));
        nrd_next   = !((state_reg == STROBE) && (op_reg == OP_RD));
        start_next = (state_reg == STROBE) && (op_reg == OP_START);
        a_next     = a_reg;
        dout_next  = dout_reg;
        if (state_reg == SETUP) begin
            a_next = addr_reg;
            if (op_reg == OP_WR) begin
                dout_next = data_reg;
            end
        end
        rsp_valid_next = (state_reg == RESP) && !rsp_done;
        cmd_ready_next = (state_next == IDLE);
        capture        = !nrd_reg && nrd_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            cmd_ready_reg  <= 1'b0;
            op_reg         <= OP_WR;
            addr_reg       <= 2'b00;
            data_reg       <= '0;
            ncs_reg        <= 1'b1;
            nrd_reg        <= 1'b1;
            nwr_reg        <= 1'b1;
            start_reg      <= 1'b0;
            a_reg          <= 2'b00;
            dout_reg       <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_status_reg <= 3'b000;
            rsp_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cmd_ready_reg <= cmd_ready_next;
            ncs_reg       <= ncs_next;
            nrd_reg       <= nrd_next;
            nwr_reg       <= nwr_next;
            start_reg     <= start_next;
            a_reg         <= a_next;
            dout_reg      <= dout_next;
            rsp_valid_reg <= rsp_valid_next;
            if (accept) begin
                op_reg         <= cmd_op;
                addr_reg       <= cmd_addr;
                data_reg       <= cmd_data;
                rsp_data_reg   <= '0;
                rsp_status_reg <= 3'b000;
                rsp_err_reg    <= (cmd_op == OP_RSVD);
            end else if (capture) begin
                // Sampled on the edge that releases nrd, while the peripheral still drives.
                rsp_data_reg   <= bus_din;
                rsp_status_reg <= {err, dir, ec};
            end
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_status = rsp_status_reg;
    assign rsp_err    = rsp_err_reg;
    assign ncs        = ncs_reg;
    assign nrd        = nrd_reg;
    assign nwr        = nwr_reg;
    assign start      = start_reg;
    assign a0         = a_reg[0];
    assign a1         = a_reg[1];
    assign bus_dout   = dout_reg;

endmodule
